// File: rtl/fir_tone_gen_pkg.sv
// Shared constants, FSM encoding and saturation helper for the FIR test-tone source.
package fir_tone_gen_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int FIR_FRAME_CLKS = 20;
  localparam int SUM_W          = 9;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SUM_W'(127))
      return 8'h7F;
    else if (s < SUM_W'(-128))
      return 8'h80;
    else
      return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fir_quarter_sine.sv
// Quarter-wave sine lookup: registers the mirrored LUT address, then the signed sample.
module fir_quarter_sine
  import fir_tone_gen_pkg::*;
#(
  parameter int LUT_AW = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LUT_AW+1:0]          phase_hi,
  input  logic                       addr_load,
  input  logic                       out_load,
  output logic signed [SAMPLE_W-1:0] sample
);

  // round(63*sin(pi/2*k/64)), k = 0..63
  localparam int SINE_Q [64] = '{
     0,  2,  3,  5,  6,  8,  9, 11, 12, 14, 15, 17, 18, 20, 21, 23,
    24, 26, 27, 28, 30, 31, 32, 34, 35, 36, 38, 39, 40, 41, 42, 43,
    45, 46, 47, 48, 49, 50, 51, 52, 52, 53, 54, 55, 56, 56, 57, 58,
    58, 59, 59, 60, 60, 61, 61, 61, 62, 62, 62, 63, 63, 63, 63, 63
  };

  if (LUT_AW != 6) begin : g_aw_check
    $error("fir_quarter_sine: table holds 64 entries, LUT_AW must be 6");
  end

  logic [1:0]              quadrant;
  logic [LUT_AW-1:0]       addr_reg;
  logic                    neg_reg;
  logic signed [SAMPLE_W-1:0] mag;

  assign quadrant = phase_hi[LUT_AW+1:LUT_AW];
  assign mag      = SAMPLE_W'(SINE_Q[addr_reg]);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      neg_reg  <= 1'b0;
      sample   <= '0;
    end else begin
      if (addr_load) begin
        // Odd quadrants run the table backwards; upper half of the cycle is negative.
        addr_reg <= quadrant[0] ? ~phase_hi[LUT_AW-1:0] : phase_hi[LUT_AW-1:0];
        neg_reg  <= quadrant[1];
      end
      if (out_load)
        sample <= neg_reg ? -mag : mag;
    end
  end

endmodule

// File: rtl/fir_tone_gen.sv
// Two-tone sine test source driving the FIR sample interface at SAMPLE_DIV clocks per sample.
// Define FIR_TONE_NOISE_EN to add LFSR dither (-8..7) in the sum stage.
module fir_tone_gen
  import fir_tone_gen_pkg::*;
#(
  parameter int SAMPLE_DIV = 20,
  parameter int PHASE_W    = 16,
  parameter int LUT_AW     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [PHASE_W-1:0]         tone_a_step,
  input  logic [PHASE_W-1:0]         tone_b_step,
  input  logic                       tone_b_on,
  output logic signed [SAMPLE_W-1:0] out_sig,
  output logic                       ready,
  output logic                       out_stb
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  if (SAMPLE_DIV < FIR_FRAME_CLKS) begin : g_div_check
    $error("fir_tone_gen: SAMPLE_DIV must be >= %0d", FIR_FRAME_CLKS);
  end

  state_t                     state_reg, state_next;
  logic [DIV_W-1:0]           div_cnt_reg;
  logic signed [SAMPLE_W-1:0] out_sig_reg;
  logic                       out_stb_reg;

  logic                       run, last, addr_load, out_load, sum_load;
  logic [PHASE_W-1:0]         steps [2];
  logic signed [SAMPLE_W-1:0] tone_sample [2];
  logic signed [SAMPLE_W-1:0] tone_b_term;
  logic signed [SUM_W-1:0]    noise_term, sum_wide;

  assign run       = (state_reg == ST_RUN);
  assign last      = run && (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));
  assign addr_load = run && (div_cnt_reg == DIV_W'(0));
  assign out_load  = run && (div_cnt_reg == DIV_W'(1));
  assign sum_load  = run && (div_cnt_reg == DIV_W'(2));

  assign steps[0] = tone_a_step;
  assign steps[1] = tone_b_step;

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // A sample period, once started, always runs to its last clock before stopping.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (en) state_next = ST_RUN;
      ST_RUN:  if (last && !en) state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_reg == ST_RUN);
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_tone
    logic [PHASE_W-1:0]         phase_reg;
    logic signed [SAMPLE_W-1:0] sample;

    // Steps are picked up only at the period boundary so a change lands on the next sample.
    always_ff @(posedge clk) begin
      if (rst || !run)
        phase_reg <= '0;
      else if (last)
        phase_reg <= phase_reg + steps[gi];
    end

    fir_quarter_sine #(.LUT_AW(LUT_AW)) u_sine (
      .clk      (clk),
      .rst      (rst),
      .phase_hi (phase_reg[PHASE_W-1 -: LUT_AW+2]),
      .addr_load(addr_load),
      .out_load (out_load),
      .sample   (sample)
    );

    assign tone_sample[gi] = sample;
  end

`ifdef FIR_TONE_NOISE_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst)
      lfsr_reg <= LFSR_SEED;
    else if (out_stb_reg)
      lfsr_reg <= {^(lfsr_reg & LFSR_TAPS), lfsr_reg[15:1]};
  end

  assign noise_term = SUM_W'(signed'(lfsr_reg[3:0]));
`else
  assign noise_term = '0;
`endif

  always_comb begin
    tone_b_term = tone_b_on ? tone_sample[1] : '0;
    sum_wide    = SUM_W'(tone_sample[0]) + SUM_W'(tone_b_term) + noise_term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      out_sig_reg <= '0;
      out_stb_reg <= 1'b0;
    end else begin
      out_stb_reg <= sum_load;
      if (!run || last)
        div_cnt_reg <= '0;
      else
        div_cnt_reg <= div_cnt_reg + 1'b1;
      if (sum_load)
        out_sig_reg <= saturate(sum_wide);
      else if (last && !en)
        out_sig_reg <= '0;
    end
  end

  assign out_sig = out_sig_reg;
  assign out_stb = out_stb_reg;

endmodule

// File: tb/tb_fir_tone_gen.sv
// Directed self-checking bench for fir_tone_gen; one line per checked transaction.
module tb_fir_tone_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [15:0]        tone_a_step;
  logic [15:0]        tone_b_step;
  logic               tone_b_on;
  logic signed [7:0]  out_sig;
  logic               ready;
  logic               out_stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_tone_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tone_a_step(tone_a_step),
    .tone_b_step(tone_b_step),
    .tone_b_on  (tone_b_on),
    .out_sig    (out_sig),
    .ready      (ready),
    .out_stb    (out_stb)
  );

  task automatic step_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Advance until out_stb is seen at a negedge or the edge budget runs out.
  task automatic wait_stb(input int limit, output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < limit) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (out_stb) seen = 1'b1;
    end
  endtask

  task automatic restart(input logic [15:0] sa, input logic [15:0] sb, input logic b_on);
    rst = 1'b1;
    en  = 1'b0;
    step_clk(1);
    rst         = 1'b0;
    tone_a_step = sa;
    tone_b_step = sb;
    tone_b_on   = b_on;
    en          = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; tone_a_step = '0; tone_b_step = '0; tone_b_on = 1'b0;
    step_clk(2);
    checks++;
    if (out_sig !== 8'sd0) begin errors++; $display("FAIL reset_out_sig got %0d want 0", out_sig); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++;
    if (out_stb !== 1'b0) begin errors++; $display("FAIL reset_out_stb got %b want 0", out_stb); end
    $display("reset: out_sig=%0d ready=%b out_stb=%b", out_sig, ready, out_stb);
    rst = 1'b0;
    step_clk(1);
  endtask

  task automatic test_zero_steps;
    int e; bit s;
    restart(16'h0000, 16'h0000, 1'b0);
    wait_stb(30, e, s);
    checks++;
    if (!s || e != 4) begin errors++; $display("FAIL zero_first_latency got %0d edges want 4 (seen=%b)", e, s); end
    for (int i = 0; i < 3; i++) begin
      wait_stb(30, e, s);
      checks++;
      if (!s || e != 20) begin errors++; $display("FAIL zero_interval[%0d] got %0d want 20", i, e); end
      checks++;
      if (out_sig !== 8'sd0) begin errors++; $display("FAIL zero_out_sig[%0d] got %0d want 0", i, out_sig); end
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready[%0d] got %b want 1", i, ready); end
      $display("zero steps sample %0d: interval=%0d out_sig=%0d ready=%b", i, e, out_sig, ready);
    end
  endtask

  task automatic test_tones;
    logic [15:0] sa_tab [6] = '{16'h4000, 16'h4000, 16'h4000, 16'h2000, 16'h0000, 16'h2000};
    logic [15:0] sb_tab [6] = '{16'h0000, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 16'h4000};
    bit          on_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int exp_tab [6][8] = '{
      '{0,  63, 0,  -63, 0,  63,  0,  -63},
      '{0, 126, 0, -126, 0, 126,  0, -126},
      '{0,   0, 0,    0, 0,   0,  0,    0},
      '{0,  45, 63,  43, 0, -45, -63, -43},
      '{0,   0, 0,    0, 0,   0,  0,    0},
      '{0, 108, 63, -20, 0,  18, -63, -106}
    };
    int e; bit s;
    for (int sc = 0; sc < 6; sc++) begin
      restart(sa_tab[sc], sb_tab[sc], on_tab[sc]);
      for (int i = 0; i < 8; i++) begin
        wait_stb(25, e, s);
        checks++;
        if (!s) begin
          errors++;
          $display("FAIL tone[%0d][%0d] no strobe within 25 clocks", sc, i);
        end else if (int'(out_sig) !== exp_tab[sc][i]) begin
          errors++;
          $display("FAIL tone[%0d][%0d] got %0d want %0d", sc, i, out_sig, exp_tab[sc][i]);
        end else begin
          $display("tone[%0d][%0d]: out_sig=%0d", sc, i, out_sig);
        end
      end
    end
  endtask

  task automatic test_stop;
    int e; bit s;
    restart(16'h4000, 16'h0000, 1'b0);
    wait_stb(25, e, s);
    step_clk(18);
    en = 1'b0;                      // divider now at 1, before this period's strobe
    wait_stb(5, e, s);
    checks++;
    if (!s || out_sig !== 8'sd63) begin errors++; $display("FAIL stop_last_sample got %0d seen=%b want 63", out_sig, s); end
    step_clk(16);
    checks++;
    if (ready !== 1'b1 || out_sig !== 8'sd63) begin
      errors++; $display("FAIL stop_before_wrap ready=%b out_sig=%0d want 1/63", ready, out_sig);
    end
    step_clk(1);
    checks++;
    if (ready !== 1'b0 || out_sig !== 8'sd0) begin
      errors++; $display("FAIL stop_after_wrap ready=%b out_sig=%0d want 0/0", ready, out_sig);
    end
    wait_stb(60, e, s);
    checks++;
    if (s) begin errors++; $display("FAIL stop_no_more_strobes got strobe after %0d clocks want none", e); end
    $display("stop: final ready=%b out_sig=%0d", ready, out_sig);
  endtask

  task automatic test_reset_mid_run;
    int e; bit s;
    restart(16'h4000, 16'h0000, 1'b0);
    wait_stb(25, e, s);
    wait_stb(25, e, s);
    checks++;
    if (out_sig !== 8'sd63) begin errors++; $display("FAIL midrst_pre got %0d want 63", out_sig); end
    rst = 1'b1;
    step_clk(1);
    checks++;
    if (out_sig !== 8'sd0 || ready !== 1'b0 || out_stb !== 1'b0) begin
      errors++; $display("FAIL midrst_clear out_sig=%0d ready=%b out_stb=%b want 0/0/0", out_sig, ready, out_stb);
    end
    rst = 1'b0;
    wait_stb(10, e, s);
    checks++;
    if (!s || e != 4) begin errors++; $display("FAIL midrst_restart_latency got %0d want 4 (seen=%b)", e, s); end
    checks++;
    if (out_sig !== 8'sd0) begin errors++; $display("FAIL midrst_restart_sample got %0d want 0", out_sig); end
    $display("mid-run reset: restart latency=%0d out_sig=%0d", e, out_sig);
  endtask

  task automatic test_noise;
    int exp_first [3] = '{1, 0, -8};
    int e; bit s;
    restart(16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 15; i++) begin
      wait_stb(25, e, s);
      checks++;
      if (!s) begin
        errors++; $display("FAIL noise[%0d] no strobe", i);
      end else if (i < 3 && int'(out_sig) !== exp_first[i]) begin
        errors++; $display("FAIL noise[%0d] got %0d want %0d", i, out_sig, exp_first[i]);
      end else if (int'(out_sig) < -8 || int'(out_sig) > 7) begin
        errors++; $display("FAIL noise_range[%0d] got %0d want -8..7", i, out_sig);
      end else begin
        $display("noise[%0d]: out_sig=%0d", i, out_sig);
      end
    end
  endtask

  initial begin
    test_reset;
`ifdef FIR_TONE_NOISE_EN
    test_noise;
`else
    test_zero_steps;
    test_tones;
    test_stop;
    test_reset_mid_run;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
